// File: rtl/led_matrix.sv
// ---------------------------------------------------------------------------
// led_matrix
//
// Column-scanned driver for a 16 x 16 LED panel. A 16-entry frame buffer
// (one 16-bit word per column) is written by a host through an asynchronous
// LOAD strobe and is scanned out one column at a time, SCAN_DIV clocks per
// column, giving a full refresh every 16*SCAN_DIV clocks.
//
// Parameters
//   SCAN_DIV    CLK cycles per displayed column (minimum 4)
//
// Ports
//   CLK         system clock, all state updates on the rising edge
//   RESET       asynchronous, active-high reset
//   column_id   buffer write address; bit 4 ignored, [3:0] select column
//   in_column   pixel data to store, bit n = row n, 1 = lit
//   LOAD        write strobe, asynchronous to CLK; a rising edge writes once
//   IN_CLR      synchronous, active-high clear of the whole frame buffer
//   column_seg  index of the column currently driven
//   out_column  row data of the driven column (registered)
//   COLUMN_CLK  one-CLK latch pulse to the panel driver per column period
//   OUT_CLR     panel blanking, high for the first two clocks of a column
// ---------------------------------------------------------------------------
module led_matrix #(
    parameter int SCAN_DIV = 256
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  column_id,
    input  logic [15:0] in_column,
    input  logic        LOAD,
    input  logic        IN_CLR,
    output logic [3:0]  column_seg,
    output logic [15:0] out_column,
    output logic        COLUMN_CLK,
    output logic        OUT_CLR
);

    localparam int              DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;

    logic load_meta;
    logic load_sync;
    logic load_prev;
    logic load_edge;

    logic [15:0] frame [16];

    // Bit 4 of the address only aliases the upper half onto the lower half.
    logic unused_id_msb;
    assign unused_id_msb = column_id[4];

    // ------------------------------------------------------------------
    // LOAD synchronizer and rising-edge detector
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the three-stage chain into a single flop.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            load_meta <= 1'b0;
            load_sync <= 1'b0;
            load_prev <= 1'b0;
        end else begin
            load_meta <= LOAD;
            load_sync <= load_meta;
            load_prev <= load_sync;
        end
    end

    // High for exactly one cycle per synchronized rising edge of LOAD.
    assign load_edge = load_sync & ~load_prev;

    // ------------------------------------------------------------------
    // Frame buffer
    // ------------------------------------------------------------------
    // NOTE: the buffer must zero asynchronously on RESET, which rules out a
    // RAM macro; it is built from flops on purpose so the reset is honoured.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < 16; k++) begin
                frame[k] <= '0;
            end
        end else if (IN_CLR) begin
            // Clear takes priority over a coinciding write.
            for (int k = 0; k < 16; k++) begin
                frame[k] <= '0;
            end
        end else if (load_edge) begin
            frame[column_id[3:0]] <= in_column;
        end
    end

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    // NOTE: a combinational block assigns its output on every path (here via
    // a full ternary) so no latch is inferred.
    always_comb begin
        div_next = (div == DIV_LAST) ? '0 : div + 1'b1;
    end

    // Strobes are decoded from div_next and registered, so they line up
    // with div itself while staying glitch-free at the pins.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            div        <= '0;
            column_seg <= '0;
            out_column <= '0;
            COLUMN_CLK <= 1'b0;
            OUT_CLR    <= 1'b1;
        end else begin
            div <= div_next;
            if (div == DIV_LAST) begin
                column_seg <= column_seg + 4'd1;
            end
            // Samples the pre-edge column index, so a new column shows its
            // data one clock after column_seg changes; OUT_CLR covers that.
            out_column <= frame[column_seg];
            OUT_CLR    <= (div_next == DIV_W'(0)) || (div_next == DIV_W'(1));
            COLUMN_CLK <= (div_next == DIV_W'(2));
        end
    end

endmodule

// File: tb/tb_led_matrix.sv
module tb_led_matrix;

    localparam int SCAN_DIV = 4;

    logic        CLK;
    logic        RESET;
    logic [4:0]  column_id;
    logic [15:0] in_column;
    logic        LOAD;
    logic        IN_CLR;
    logic [3:0]  column_seg;
    logic [15:0] out_column;
    logic        COLUMN_CLK;
    logic        OUT_CLR;

    int checks = 0;
    int errors = 0;

    led_matrix #(.SCAN_DIV(SCAN_DIV)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .column_id  (column_id),
        .in_column  (in_column),
        .LOAD       (LOAD),
        .IN_CLR     (IN_CLR),
        .column_seg (column_seg),
        .out_column (out_column),
        .COLUMN_CLK (COLUMN_CLK),
        .OUT_CLR    (OUT_CLR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          do_wr;
        logic [4:0]  id;
        logic [15:0] data;
        logic [3:0]  rd_col;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Host write: LOAD held 4 cycles high, data held well past the write.
    task automatic do_write(input logic [4:0] id, input logic [15:0] data);
        @(negedge CLK);
        column_id = id;
        in_column = data;
        LOAD      = 1'b1;
        repeat (4) @(negedge CLK);
        LOAD = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    // Stop at the negedge where column k is displayed with div = 2.
    task automatic wait_seg(input logic [3:0] k, output bit found);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge CLK);
            if (column_seg == k && COLUMN_CLK == 1'b1) found = 1'b1;
        end
    endtask

    task automatic read_col(input string name, input logic [3:0] k, input logic [15:0] exp);
        bit found;
        wait_seg(k, found);
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for column %0d", name, k);
        end else begin
            check(name, {16'h0, out_column}, {16'h0, exp});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        int div_m;
        int seg_m;
        int pulses;

        vecs[0] = '{1'b1, 5'd3,  16'hA5A5, 4'd3,  16'hA5A5};
        vecs[1] = '{1'b0, 5'd0,  16'h0000, 4'd2,  16'h0000};
        vecs[2] = '{1'b0, 5'd0,  16'h0000, 4'd4,  16'h0000};
        vecs[3] = '{1'b1, 5'd19, 16'h00FF, 4'd3,  16'h00FF};
        vecs[4] = '{1'b1, 5'd0,  16'h1234, 4'd0,  16'h1234};
        vecs[5] = '{1'b1, 5'd31, 16'h8001, 4'd15, 16'h8001};
        vecs[6] = '{1'b1, 5'd16, 16'hBEEF, 4'd0,  16'hBEEF};
        vecs[7] = '{1'b0, 5'd0,  16'h0000, 4'd3,  16'h00FF};

        RESET     = 1'b1;
        LOAD      = 1'b0;
        IN_CLR    = 1'b0;
        column_id = '0;
        in_column = '0;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst column_seg", {28'h0, column_seg}, 32'd0);
        check("rst out_column", {16'h0, out_column}, 32'd0);
        check("rst COLUMN_CLK", {31'h0, COLUMN_CLK}, 32'd0);
        check("rst OUT_CLR",    {31'h0, OUT_CLR},    32'd1);

        // 64-cycle scan with SCAN_DIV = 4
        RESET  = 1'b0;
        div_m  = 0;
        seg_m  = 0;
        pulses = 0;
        for (int c = 0; c < 64; c++) begin
            @(posedge CLK);
            if (div_m == SCAN_DIV - 1) seg_m = (seg_m + 1) % 16;
            div_m = (div_m + 1) % SCAN_DIV;
            @(negedge CLK);
            check($sformatf("scan%0d column_seg", c), {28'h0, column_seg}, seg_m);
            check($sformatf("scan%0d OUT_CLR", c),    {31'h0, OUT_CLR},    (div_m < 2) ? 1 : 0);
            check($sformatf("scan%0d COLUMN_CLK", c), {31'h0, COLUMN_CLK}, (div_m == 2) ? 1 : 0);
            if (COLUMN_CLK) pulses++;
        end
        check("COLUMN_CLK pulse count", pulses, 16);

        // Table-driven writes and readbacks (includes aliasing of ids 16-31)
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_wr) do_write(vecs[i].id, vecs[i].data);
            read_col($sformatf("vec%0d col%0d", i, vecs[i].rd_col), vecs[i].rd_col, vecs[i].exp);
        end

        // Fill, then clear coinciding with a detected write
        for (int k = 0; k < 16; k++) do_write(5'(k), 16'hFFFF);
        read_col("fill col10", 4'd10, 16'hFFFF);
        read_col("fill col5",  4'd5,  16'hFFFF);
        @(negedge CLK);
        column_id = 5'd5;
        in_column = 16'h5A5A;
        LOAD      = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        IN_CLR = 1'b1;            // high across the third edge, the write edge
        @(negedge CLK);
        IN_CLR = 1'b0;
        repeat (2) @(negedge CLK);
        LOAD = 1'b0;
        repeat (4) @(negedge CLK);
        for (int k = 0; k < 16; k++) read_col($sformatf("clr col%0d", k), 4'(k), 16'h0000);

        // Write the displayed column: out_column changes one CLK after write
        wait_seg(4'd6, found);
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL live write: timeout waiting for column 6");
        end else begin
            column_id = 5'd7;
            in_column = 16'hCAFE;
            LOAD      = 1'b1;
            @(negedge CLK);
            @(negedge CLK);
            check("live column_seg", {28'h0, column_seg}, 32'd7);
            @(negedge CLK);
            check("live out_column write cycle", {16'h0, out_column}, 32'h0000);
            @(negedge CLK);
            check("live out_column next cycle",  {16'h0, out_column}, 32'hCAFE);
            LOAD = 1'b0;
            repeat (4) @(negedge CLK);
        end

        // Reset mid-scan with a nonzero buffer
        do_write(5'd9, 16'h9999);
        wait_seg(4'd9, found);
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL midrst: timeout waiting for column 9");
        end else begin
            check("midrst pre out_column", {16'h0, out_column}, 32'h9999);
            #2 RESET = 1'b1;
            #1;
            check("midrst column_seg", {28'h0, column_seg}, 32'd0);
            check("midrst out_column", {16'h0, out_column}, 32'd0);
            check("midrst COLUMN_CLK", {31'h0, COLUMN_CLK}, 32'd0);
            check("midrst OUT_CLR",    {31'h0, OUT_CLR},    32'd1);
            repeat (2) @(negedge CLK);
            RESET = 1'b0;
            for (int k = 0; k < 16; k++) read_col($sformatf("postrst col%0d", k), 4'(k), 16'h0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
